// File: rtl/pipe_mem_wb_chain.sv
// MEM/WB pipeline chain: DEPTH elastic stages with bubble collapse, flush and
// youngest-first register forwarding from any in-flight write.
module pipe_mem_wb_chain #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [DATA_W-1:0] mmo,
  input  logic [DATA_W-1:0] malu,
  input  logic [RN_W-1:0]   mrn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [DATA_W-1:0] wmo,
  output logic [DATA_W-1:0] walu,
  output logic [RN_W-1:0]   wrn,
  input  logic [RN_W-1:0]   fwd_rn,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [2:0]        occ
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
    $error("pipe_mem_wb_chain: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             wreg_q, wreg_d;
  logic [DEPTH-1:0]             m2reg_q, m2reg_d;
  logic [DEPTH-1:0][DATA_W-1:0] mo_q, mo_d;
  logic [DEPTH-1:0][DATA_W-1:0] alu_q, alu_d;
  logic [DEPTH-1:0][RN_W-1:0]   rn_q, rn_d;
  logic [DEPTH-1:0]             rdy;
  logic                         fwd_hit_c;
  logic [DATA_W-1:0]            fwd_data_c;
  logic [2:0]                   occ_c;

  // A stage can move whenever some stage at or beyond it is empty, or the sink drains.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign rdy[g] = out_ready | ~(&valid_q[DEPTH-1:g]);
  end

  always_comb begin
    valid_d = valid_q;
    wreg_d  = wreg_q;
    m2reg_d = m2reg_q;
    mo_d    = mo_q;
    alu_d   = alu_q;
    rn_d    = rn_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      // Payload only follows a valid entry, so vacated stages keep their last contents.
      if (rdy[0]) begin
        valid_d[0] = in_valid;
        if (in_valid) begin
          wreg_d[0]  = mwreg;
          m2reg_d[0] = mm2reg;
          mo_d[0]    = mmo;
          alu_d[0]   = malu;
          rn_d[0]    = mrn;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) begin
            wreg_d[i]  = wreg_q[i-1];
            m2reg_d[i] = m2reg_q[i-1];
            mo_d[i]    = mo_q[i-1];
            alu_d[i]   = alu_q[i-1];
            rn_d[i]    = rn_q[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      valid_q <= '0;
      wreg_q  <= '0;
      m2reg_q <= '0;
      mo_q    <= '0;
      alu_q   <= '0;
      rn_q    <= '0;
    end else begin
      valid_q <= valid_d;
      wreg_q  <= wreg_d;
      m2reg_q <= m2reg_d;
      mo_q    <= mo_d;
      alu_q   <= alu_d;
      rn_q    <= rn_d;
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (fwd_rn != '0 && valid_q[i] && wreg_q[i] && rn_q[i] == fwd_rn) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = m2reg_q[i] ? mo_q[i] : alu_q[i];
      end
    end
  end

  always_comb begin
    occ_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_c = occ_c + {2'b00, valid_q[i]};
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = valid_q[DEPTH-1] & ~flush;
  assign wwreg     = wreg_q[DEPTH-1] & out_valid;
  assign wm2reg    = m2reg_q[DEPTH-1] & out_valid;
  assign wmo       = mo_q[DEPTH-1];
  assign walu      = alu_q[DEPTH-1];
  assign wrn       = rn_q[DEPTH-1];
  assign fwd_hit   = fwd_hit_c;
  assign fwd_data  = fwd_data_c;
  assign occ       = occ_c;

endmodule

// File: tb/tb_pipe_mem_wb_chain.sv
// Bench for pipe_mem_wb_chain: directed DEPTH=2 scenarios against a slot model,
// plus randomized handshake scoreboards on DEPTH=1 and DEPTH=4 instances.
module tb_pipe_mem_wb_chain;

  logic clk = 1'b0;
  logic clrn = 1'b1;
  logic clrn_r = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // DEPTH=2 device
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, mwreg = 1'b0, mm2reg = 1'b0;
  logic [31:0] mmo = '0, malu = '0;
  logic [4:0]  mrn = '0, fwd_rn = '0;
  logic        in_ready, out_valid, wwreg, wm2reg, fwd_hit;
  logic [31:0] wmo, walu, fwd_data;
  logic [4:0]  wrn;
  logic [2:0]  occ;

  pipe_mem_wb_chain #(.DATA_W(32), .RN_W(5), .DEPTH(2)) dut2 (
    .clk(clk), .clrn(clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mwreg(mwreg), .mm2reg(mm2reg), .mmo(mmo), .malu(malu), .mrn(mrn),
    .out_valid(out_valid), .out_ready(out_ready), .wwreg(wwreg), .wm2reg(wm2reg),
    .wmo(wmo), .walu(walu), .wrn(wrn), .fwd_rn(fwd_rn), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .occ(occ)
  );

  // DEPTH=1 (index 0) and DEPTH=4 (index 1) devices for random traffic
  logic        r_iv[2], r_or[2], r_ir[2], r_ov[2], r_ww[2], r_wm[2], r_fh[2];
  logic [31:0] r_seq[2], r_wmo[2], r_walu[2], r_fd[2];
  logic [4:0]  r_wrn[2];
  logic [2:0]  r_occ[2];

  pipe_mem_wb_chain #(.DATA_W(32), .RN_W(5), .DEPTH(1)) dut1 (
    .clk(clk), .clrn(clrn_r), .flush(1'b0), .in_valid(r_iv[0]), .in_ready(r_ir[0]),
    .mwreg(1'b1), .mm2reg(1'b0), .mmo(~r_seq[0]), .malu(r_seq[0]), .mrn(r_seq[0][4:0]),
    .out_valid(r_ov[0]), .out_ready(r_or[0]), .wwreg(r_ww[0]), .wm2reg(r_wm[0]),
    .wmo(r_wmo[0]), .walu(r_walu[0]), .wrn(r_wrn[0]), .fwd_rn(5'd0), .fwd_hit(r_fh[0]),
    .fwd_data(r_fd[0]), .occ(r_occ[0])
  );

  pipe_mem_wb_chain #(.DATA_W(32), .RN_W(5), .DEPTH(4)) dut4 (
    .clk(clk), .clrn(clrn_r), .flush(1'b0), .in_valid(r_iv[1]), .in_ready(r_ir[1]),
    .mwreg(1'b1), .mm2reg(1'b0), .mmo(~r_seq[1]), .malu(r_seq[1]), .mrn(r_seq[1][4:0]),
    .out_valid(r_ov[1]), .out_ready(r_or[1]), .wwreg(r_ww[1]), .wm2reg(r_wm[1]),
    .wmo(r_wmo[1]), .walu(r_walu[1]), .wrn(r_wrn[1]), .fwd_rn(5'd0), .fwd_hit(r_fh[1]),
    .fwd_data(r_fd[1]), .occ(r_occ[1])
  );

  // Slot model for the DEPTH=2 device: slot 0 youngest, slot D-1 presented downstream.
  localparam int D = 2;
  typedef struct packed {
    logic        v;
    logic        wreg;
    logic        m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
  } ent_t;

  ent_t        slot[D];
  ent_t        in_e;
  logic        rst_seen = 1'b0;
  logic        room, e_ov, e_hit;
  logic [31:0] e_fd;
  int          e_cnt, hole;

  always @(posedge clrn) rst_seen = 1'b1;

  always @(negedge clk) begin
    if (clrn || rst_seen) begin
      for (int j = 0; j < D; j++) slot[j] = '0;
      rst_seen = 1'b0;
    end
    room = out_ready;
    e_cnt = 0;
    for (int j = 0; j < D; j++) begin
      if (!slot[j].v) room = 1'b1;
      else e_cnt++;
    end
    e_hit = 1'b0;
    e_fd = '0;
    for (int j = 0; j < D; j++) begin
      if (!e_hit && slot[j].v && slot[j].wreg && fwd_rn != 5'd0 && slot[j].rn == fwd_rn) begin
        e_hit = 1'b1;
        e_fd = slot[j].m2reg ? slot[j].mo : slot[j].alu;
      end
    end
    e_ov = slot[D-1].v && !flush;
    chk("m_in_ready", 32'(in_ready), 32'(room && !flush));
    chk("m_out_valid", 32'(out_valid), 32'(e_ov));
    chk("m_wwreg", 32'(wwreg), 32'(slot[D-1].wreg && e_ov));
    chk("m_wm2reg", 32'(wm2reg), 32'(slot[D-1].m2reg && e_ov));
    chk("m_wmo", wmo, slot[D-1].mo);
    chk("m_walu", walu, slot[D-1].alu);
    chk("m_wrn", 32'(wrn), 32'(slot[D-1].rn));
    chk("m_fwd_hit", 32'(fwd_hit), 32'(e_hit));
    chk("m_fwd_data", fwd_data, e_fd);
    chk("m_occ", 32'(occ), 32'(e_cnt));
    if (!clrn) begin
      if (flush) begin
        for (int j = 0; j < D; j++) slot[j].v = 1'b0;
      end else if (room) begin
        hole = D - 1;
        if (!out_ready) begin
          for (int j = 0; j < D; j++) if (!slot[j].v) hole = j;
        end
        for (int j = hole; j >= 1; j--) begin
          if (slot[j-1].v) slot[j] = slot[j-1];
          else slot[j].v = 1'b0;
        end
        in_e = '{v: in_valid, wreg: mwreg, m2reg: mm2reg, mo: mmo, alu: malu, rn: mrn};
        if (in_e.v) slot[0] = in_e;
        else slot[0].v = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic wr, input logic m2, input logic [31:0] mo,
                       input logic [31:0] alu, input logic [4:0] rn);
    in_valid = v; mwreg = wr; mm2reg = m2; mmo = mo; malu = alu; mrn = rn;
  endtask

  logic rand_done = 1'b0;

  initial begin : rnd
    int   acc[2], del[2], dep[2];
    logic a_now[2];
    dep[0] = 1; dep[1] = 4;
    for (int k = 0; k < 2; k++) begin
      acc[k] = 0; del[k] = 0; r_iv[k] = 1'b0; r_or[k] = 1'b0; r_seq[k] = '0; a_now[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 clrn_r = 1'b0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("r_occ_count", 32'(r_occ[k]), 32'(acc[k] - del[k]));
        chk("r_occ_bound", 32'(int'(r_occ[k]) <= dep[k]), 32'd1);
        chk("r_fwd_idle", 32'(r_fh[k]) | r_fd[k], 32'd0);
        a_now[k] = r_iv[k] & r_ir[k];
        if (r_ov[k] && r_or[k]) begin
          chk("r_order", r_walu[k], 32'(del[k]));
          chk("r_payload", r_wmo[k], ~32'(del[k]));
          chk("r_wrn", 32'(r_wrn[k]), 32'(del[k] % 32));
          chk("r_ctrl", 32'({r_ww[k], r_wm[k]}), 32'd2);
          del[k]++;
        end
        if (a_now[k]) acc[k]++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (a_now[k]) r_seq[k] = r_seq[k] + 32'd1;
        if (!r_iv[k] || a_now[k]) r_iv[k] = (c < 680) && ($urandom_range(0, 3) != 0);
        r_or[k] = (c >= 680) || ($urandom_range(0, 2) != 0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk("r_all_delivered", 32'(del[k]), 32'(acc[k]));
      chk("r_traffic", 32'(acc[k] > 100), 32'd1);
    end
    rand_done = 1'b1;
  end

  initial begin
    tick();
    tick();
    clrn = 1'b0;

    // single entry, unstalled: out_valid two edges after acceptance
    out_ready = 1'b1;
    offer(1, 1, 0, 32'h0, 32'h11, 5'd3);
    #2 chk("lat_in_ready", 32'(in_ready), 32'd1);
    chk("lat_occ0", 32'(occ), 32'd0);
    tick(); offer(0, 0, 0, 32'h0, 32'h0, 5'd0);
    #2 chk("lat_occ1", 32'(occ), 32'd1);
    chk("lat_ov1", 32'(out_valid), 32'd0);
    tick();
    #2 chk("lat_ov2", 32'(out_valid), 32'd1);
    chk("lat_walu", walu, 32'h11);
    chk("lat_wrn", 32'(wrn), 32'd3);
    chk("lat_wwreg", 32'(wwreg), 32'd1);
    tick();
    #2 chk("lat_drained", 32'(occ), 32'd0);

    // stalled fill, backpressure, then in-order drain
    out_ready = 1'b0;
    tick(); offer(1, 1, 0, 32'h0, 32'hA1, 5'd1);
    #2 chk("bp_rdy_a", 32'(in_ready), 32'd1);
    tick(); offer(1, 1, 0, 32'h0, 32'hB2, 5'd2);
    #2 chk("bp_rdy_b", 32'(in_ready), 32'd1);
    chk("bp_occ1", 32'(occ), 32'd1);
    tick(); offer(1, 1, 0, 32'h0, 32'hC3, 5'd3);
    #2 chk("bp_rdy_c", 32'(in_ready), 32'd0);
    chk("bp_occ2", 32'(occ), 32'd2);
    chk("bp_head_a", walu, 32'hA1);
    tick();
    #2 chk("bp_hold_occ", 32'(occ), 32'd2);
    chk("bp_hold_a", walu, 32'hA1);
    out_ready = 1'b1;
    #1 chk("bp_rdy_release", 32'(in_ready), 32'd1);
    tick(); offer(0, 0, 0, 32'h0, 32'h0, 5'd0);
    #2 chk("bp_head_b", walu, 32'hB2);
    chk("bp_occ_b", 32'(occ), 32'd2);
    tick();
    #2 chk("bp_head_c", walu, 32'hC3);
    chk("bp_occ_c", 32'(occ), 32'd1);
    tick();
    #2 chk("bp_empty_ov", 32'(out_valid), 32'd0);
    chk("bp_empty_occ", 32'(occ), 32'd0);

    // forwarding: youngest match wins
    out_ready = 1'b0;
    tick(); offer(1, 1, 0, 32'h0, 32'hBB, 5'd5);
    tick(); offer(1, 1, 1, 32'hAA, 32'h0, 5'd5);
    tick(); offer(0, 0, 0, 32'h0, 32'h0, 5'd0);
    fwd_rn = 5'd5;
    #2 chk("fwd_hit5", 32'(fwd_hit), 32'd1);
    chk("fwd_data5", fwd_data, 32'hAA);
    fwd_rn = 5'd0;
    #1 chk("fwd_hit0", 32'(fwd_hit), 32'd0);
    chk("fwd_data0", fwd_data, 32'h0);
    fwd_rn = 5'd5;

    // flush of a full chain
    tick(); offer(1, 1, 0, 32'h0, 32'h77, 5'd9);
    out_ready = 1'b1; flush = 1'b1;
    #2 chk("fl_in_ready", 32'(in_ready), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_wwreg", 32'(wwreg), 32'd0);
    chk("fl_fwd_hit", 32'(fwd_hit), 32'd1);
    chk("fl_fwd_data", fwd_data, 32'hAA);
    tick(); flush = 1'b0; offer(0, 0, 0, 32'h0, 32'h0, 5'd0);
    #2 chk("fl_occ", 32'(occ), 32'd0);
    chk("fl_ov", 32'(out_valid), 32'd0);
    chk("fl_walu_kept", walu, 32'hBB);
    chk("fl_wrn_kept", 32'(wrn), 32'd5);

    // async reset mid-stall
    out_ready = 1'b0; fwd_rn = 5'd7;
    tick(); offer(1, 1, 0, 32'h0, 32'h31, 5'd7);
    tick(); offer(1, 1, 0, 32'h0, 32'h32, 5'd8);
    tick(); offer(0, 0, 0, 32'h0, 32'h0, 5'd0);
    #1 chk("rs_pre_occ", 32'(occ), 32'd2);
    chk("rs_pre_hit", 32'(fwd_hit), 32'd1);
    clrn = 1'b1;
    #1 chk("rs_ov", 32'(out_valid), 32'd0);
    chk("rs_occ", 32'(occ), 32'd0);
    chk("rs_walu", walu, 32'h0);
    chk("rs_wrn", 32'(wrn), 32'd0);
    chk("rs_hit", 32'(fwd_hit), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    clrn = 1'b0;
    out_ready = 1'b1;
    offer(1, 1, 0, 32'h0, 32'h55, 5'd4);
    tick(); offer(0, 0, 0, 32'h0, 32'h0, 5'd0);
    #2 chk("rs_new_occ", 32'(occ), 32'd1);
    chk("rs_new_ov1", 32'(out_valid), 32'd0);
    tick();
    #2 chk("rs_new_ov2", 32'(out_valid), 32'd1);
    chk("rs_new_walu", walu, 32'h55);
    chk("rs_new_wrn", 32'(wrn), 32'd4);

    for (int i = 0; i < 5000 && !rand_done; i++) @(posedge clk);
    chk("rand_timeout", 32'(rand_done), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_mem_wb_chain.md
PIPE_MEM_WB_CHAIN -- requirements
Module: pipe_mem_wb_chain

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, width of memory-output and ALU-result fields.
- RN_W, 5, width of destination register number.
- DEPTH, 2, number of stages, legal range 1..4.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  clock, all state on rising edge.
- clrn  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all stages.
- in_valid  in  1  upstream entry offered.
- in_ready  out  1  chain accepts entry this cycle.
- mwreg, mm2reg  in  1 each  register-write and mem-to-reg controls.
- mmo, malu  in  DATA_W each  memory data and ALU result.
- mrn  in  RN_W  destination register.
- out_valid  out  1  oldest stage holds an entry.
- out_ready  in  1  downstream consumes oldest entry.
- wwreg, wm2reg  out  1 each  oldest-stage controls, gated by out_valid.
- wmo, walu  out  DATA_W each  oldest-stage payload.
- wrn  out  RN_W  oldest-stage destination.
- fwd_rn  in  RN_W  forwarding query register.
- fwd_hit  out  1  query matches an in-flight write.
- fwd_data  out  DATA_W  forwarded value.
- occ  out  3  number of valid stages, 0..DEPTH.

Function
REQ-003 Stages SHALL be indexed 0 (input side) to DEPTH-1 (output side); each holds valid, wreg, m2reg, mo, alu, rn.
REQ-004 Stage DEPTH-1 SHALL be ready when not valid or out_ready=1; stage i<DEPTH-1 SHALL be ready when not valid or stage i+1 ready; in_ready SHALL equal stage-0 ready AND NOT flush.
REQ-005 A ready stage SHALL load its predecessor's contents (stage 0: input fields with valid=in_valid AND in_ready) at the clock edge; a non-ready stage SHALL hold all fields.
REQ-006 Bubbles SHALL collapse: an empty stage SHALL accept from its predecessor even while downstream is stalled.
REQ-007 Unstalled latency SHALL be DEPTH cycles from input acceptance to out_valid=1; throughput SHALL be one entry per cycle.
REQ-008 Payload fields of a vacated stage SHALL retain their last values; only valid SHALL clear.
REQ-009 out_valid SHALL equal stage DEPTH-1 valid AND NOT flush; wwreg and wm2reg SHALL be the stage values ANDed with out_valid; wmo, walu, wrn SHALL show stage DEPTH-1 fields unconditionally.
REQ-010 A transfer SHALL occur only when out_valid=1 and out_ready=1.
REQ-011 flush=1 SHALL clear every valid bit at the next edge, accept no input, and perform no output transfer that cycle; payloads SHALL be unchanged.
REQ-012 fwd_hit SHALL be 1 when some valid stage has wreg=1, rn=fwd_rn and fwd_rn!=0; flush SHALL NOT affect it combinationally.
REQ-013 On multiple matches, the lowest-index (youngest) stage SHALL win; fwd_data SHALL be that stage's mo if m2reg=1, else its alu; fwd_data SHALL be 0 when fwd_hit=0.
REQ-014 occ SHALL equal the count of valid stages, updated every edge.
REQ-015 DEPTH outside 1..4 SHALL be an elaboration error.

Reset
REQ-016 clrn=1 SHALL immediately clear all valid, wreg, m2reg, mo, alu and rn state to 0, regardless of clk.
REQ-017 During reset, out_valid, wwreg, wm2reg, fwd_hit, occ, wmo, walu, wrn and fwd_data SHALL be 0, and in_ready SHALL be 1 unless flush=1.
REQ-018 Reset asserted mid-stall SHALL discard all in-flight entries; the first edge after release SHALL behave as an empty chain.

Verification
REQ-019 DEPTH=2, out_ready=1; inject alu=0x11,rn=3,wreg=1 at cycle 0 -> out_valid, walu=0x11, wrn=3, wwreg=1 at cycle 2; occ=1 at cycle 1.
REQ-020 DEPTH=2, out_ready=0; offer three back-to-back entries -> first two accepted, in_ready=0 on third, occ=2; raise out_ready -> entries exit in order, none lost or duplicated.
REQ-021 Stage0 rn=5,wreg=1,m2reg=1,mo=0xAA and stage1 rn=5,wreg=1,alu=0xBB; fwd_rn=5 -> fwd_hit=1, fwd_data=0xAA; fwd_rn=0 -> fwd_hit=0, fwd_data=0.
REQ-022 Chain full, flush=1 one cycle with in_valid=1 -> no transfer that cycle, occ=0 next cycle, input not accepted, wwreg=0.
REQ-023 Chain full and stalled, clrn pulsed between edges -> outputs 0 immediately; after release a new entry emerges after DEPTH cycles.
REQ-024 DEPTH=1 and DEPTH=4 regressions: randomized valid/ready with scoreboard -> in-order delivery, occ never exceeds DEPTH.
